// File: rtl/nibble_serial_addsub.sv
// Purpose : 16-bit signed add/subtract computed one nibble per cycle through a 4-bit slice, with a saturated result.
// Latency : start accepted at edge E, nibbles processed at E+1..E+4, done is high in the cycle after E+4.
// Backpressure: none; start is ignored while busy, and is accepted in the done cycle for back-to-back operations.
//
// Ports:
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   start, sub      begin an operation; sub=1 selects a-b, otherwise a+b
//   a, b            16-bit two's complement operands, sampled with start
//   busy, done      busy while nibbles are in flight; done is a one-cycle result pulse
//   sum             saturated registered result
//   ovfl, z, n      signed overflow, zero and negative flags of the saturated result
module nibble_serial_addsub (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        sub,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] sum,
  output logic        ovfl,
  output logic        z,
  output logic        n
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        carry_q, carry_d;
  logic [15:0] a_q, a_d;
  logic [15:0] beff_q, beff_d;
  logic [15:0] raw_q, raw_d;
  logic [15:0] sum_q, sum_d;
  logic        ovfl_q, ovfl_d;
  logic        z_q, z_d;
  logic        n_q, n_d;

  // Nibble slice datapath
  logic [3:0]  idx;
  logic [4:0]  nib;
  logic [15:0] raw_full;
  logic        ovf_w;
  logic [15:0] sat_w;

  always_comb begin
    idx      = {cnt_q, 2'b00};
    nib      = {1'b0, a_q[idx +: 4]} + {1'b0, beff_q[idx +: 4]} + {4'b0000, carry_q};
    // Partial sum with the current nibble merged in; on the last nibble this is the full raw result.
    raw_full = raw_q;
    raw_full[idx +: 4] = nib[3:0];
    // Signed overflow depends only on operand/result signs; the final carry-out is not consulted.
    ovf_w    = (a_q[15] == beff_q[15]) && (raw_full[15] != a_q[15]);
    if (ovf_w) begin
      sat_w = a_q[15] ? 16'h8000 : 16'h7FFF;
    end else begin
      sat_w = raw_full;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    beff_d  = beff_q;
    raw_d   = raw_q;
    sum_d   = sum_q;
    ovfl_d  = ovfl_q;
    z_d     = z_q;
    n_d     = n_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
          a_d     = a;
          beff_d  = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = 2'd0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        raw_d   = raw_full;
        carry_d = nib[4];
        cnt_d   = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          sum_d   = sat_w;
          ovfl_d  = ovf_w;
          z_d     = (sat_w == 16'h0000);
          n_d     = sat_w[15];
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      carry_q <= 1'b0;
      a_q     <= 16'h0000;
      beff_q  <= 16'h0000;
      raw_q   <= 16'h0000;
      sum_q   <= 16'h0000;
      ovfl_q  <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      beff_q  <= beff_d;
      raw_q   <= raw_d;
      sum_q   <= sum_d;
      ovfl_q  <= ovfl_d;
      z_q     <= z_d;
      n_q     <= n_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign ovfl = ovfl_q;
  assign z    = z_q;
  assign n    = n_q;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Purpose : scoreboard bench for nibble_serial_addsub; expected results come from an integer reference model.
// Latency : inputs driven on falling edges, outputs sampled 1ns after rising edges.
// Backpressure: none; the bench issues starts only when the DUT is expected to accept them.
module tb_nibble_serial_addsub;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic [15:0] a = 16'h0000;
  logic [15:0] b = 16'h0000;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        ovfl;
  logic        z;
  logic        n;

  typedef struct packed {
    logic [15:0] sum;
    logic        ovfl;
    logic        z;
    logic        n;
  } exp_t;

  exp_t exp_q[$];
  exp_t hold = '0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy_run = 0;
  int   n_done = 0;
  int   last_done_cyc = 0;
  int   prev_done_cyc = 0;

  nibble_serial_addsub dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .ovfl  (ovfl),
    .z     (z),
    .n     (n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: exact integer add/sub, then clamp to the signed 16-bit range.
  function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv, input logic s);
    exp_t e;
    int   r;
    r = s ? (int'($signed(av)) - int'($signed(bv))) : (int'($signed(av)) + int'($signed(bv)));
    e.ovfl = 1'b0;
    if (r > 32767) begin
      e.sum  = 16'h7FFF;
      e.ovfl = 1'b1;
    end else if (r < -32768) begin
      e.sum  = 16'h8000;
      e.ovfl = 1'b1;
    end else begin
      e.sum = r[15:0];
    end
    e.z = (e.sum == 16'h0000);
    e.n = e.sum[15];
    return e;
  endfunction

  // Output monitor: pops the scoreboard on done, checks busy length and result stability otherwise.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      hold     = '0;
      busy_run = 0;
    end else begin
      #1;
      cyc++;
      if (busy) busy_run++;
      if (done) begin
        n_done++;
        prev_done_cyc = last_done_cyc;
        last_done_cyc = cyc;
        check("busy_len", busy_run, 4);
        busy_run = 0;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          hold = exp_q.pop_front();
          check("sum",  {16'h0, sum},  {16'h0, hold.sum});
          check("ovfl", {31'h0, ovfl}, {31'h0, hold.ovfl});
          check("z",    {31'h0, z},    {31'h0, hold.z});
          check("n",    {31'h0, n},    {31'h0, hold.n});
        end
      end else begin
        check("stable", {13'h0, sum, ovfl, z, n}, {13'h0, hold.sum, hold.ovfl, hold.z, hold.n});
      end
    end
  end

  task automatic issue(input logic [15:0] av, input logic [15:0] bv, input logic s);
    @(negedge clk);
    start = 1'b1;
    a     = av;
    b     = bv;
    sub   = s;
    exp_q.push_back(model(av, bv, s));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_quiet();
    int t = 0;
    while ((exp_q.size() != 0 || busy || done) && t < 30) begin
      @(negedge clk);
      t++;
    end
    check("timeout", {31'h0, (t < 30)}, 32'h1);
  endtask

  task automatic op(input logic [15:0] av, input logic [15:0] bv, input logic s);
    issue(av, bv, s);
    wait_quiet();
  endtask

  initial begin
    int d0;
    int t;
    #12;
    check("rst_outs", {12'h0, sum, ovfl, z, n, busy, done}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    op(16'h1234, 16'h1111, 1'b0);
    op(16'h7FFF, 16'h0001, 1'b0);
    op(16'hFFFF, 16'h0001, 1'b0);
    op(16'h8000, 16'h0001, 1'b1);
    op(16'h0005, 16'h0005, 1'b1);
    op(16'h0000, 16'h8000, 1'b1);
    op(16'h8000, 16'h8000, 1'b0);
    for (int i = 0; i < 10; i++) begin
      op(16'($urandom), 16'($urandom), 1'($urandom));
    end

    // start held during RUN with other operands must be ignored
    d0 = n_done;
    issue(16'h0100, 16'h0023, 1'b0);
    for (int i = 0; i < 3; i++) begin
      start = 1'b1;
      a     = 16'($urandom);
      b     = 16'($urandom);
      sub   = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    wait_quiet();
    repeat (6) @(negedge clk);
    check("ignore_done_cnt", n_done - d0, 1);

    // back-to-back: start in the DONE cycle
    issue(16'h4000, 16'h4000, 1'b0);
    t = 0;
    while (!done && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("b2b_wait", {31'h0, done}, 32'h1);
    start = 1'b1;
    a     = 16'hF000;
    b     = 16'h0FFF;
    sub   = 1'b1;
    exp_q.push_back(model(16'hF000, 16'h0FFF, 1'b1));
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", {31'h0, busy}, 32'h1);
    wait_quiet();
    check("b2b_spacing", last_done_cyc - prev_done_cyc, 5);

    // reset in the cycle that processes nibble 2
    issue(16'h1111, 16'h2222, 1'b0);
    @(negedge clk);
    @(negedge clk);
    d0 = n_done;
    rst_n = 1'b0;
    #1;
    check("abort_outs", {12'h0, sum, ovfl, z, n, busy, done}, 32'h0);
    #1;
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_no_done", n_done - d0, 0);
    check("abort_idle", {30'h0, busy, done}, 32'h0);

    op(16'h0ABC, 16'h0123, 1'b0);
    op(16'h8001, 16'h0002, 1'b1);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_serial_addsub.md
NIBBLE_SERIAL_ADDSUB -- requirements
Module: nibble_serial_addsub

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: start  input  1  request to begin an operation; sampled on rising clk.
REQ-004 SHALL have port: sub  input  1  0 = A+B, 1 = A-B; sampled with start.
REQ-005 SHALL have port: a  input  16  operand A, two's complement; sampled with start.
REQ-006 SHALL have port: b  input  16  operand B, two's complement; sampled with start.
REQ-007 SHALL have port: busy  output  1  high while nibbles are being processed.
REQ-008 SHALL have port: done  output  1  one-cycle pulse; result outputs valid and updated.
REQ-009 SHALL have port: sum  output  16  saturated result, registered.
REQ-010 SHALL have port: ovfl  output  1  signed overflow of the completed operation.
REQ-011 SHALL have port: z  output  1  saturated result equals 0x0000.
REQ-012 SHALL have port: n  output  1  sum[15] after saturation.

Function
REQ-013 SHALL implement an FSM with states IDLE, RUN, DONE, plus a 2-bit nibble counter cnt.
REQ-014 SHALL accept start only in IDLE or DONE; start while in RUN SHALL be ignored, with no effect on operands or results.
REQ-015 On accepted start (edge E), SHALL latch A, Beff = sub ? ~b : b, and carry register = sub; SHALL set cnt=0 and go to RUN.
REQ-016 In RUN, each edge SHALL add nibble cnt of A and Beff plus the carry register through a 4-bit adder slice, write the 4-bit result into nibble cnt of an internal partial-sum register, store the carry-out, and increment cnt.
REQ-017 Nibble order SHALL be 0 (bits 3:0) to 3 (bits 15:12); the carry SHALL propagate between nibbles only through the carry register.
REQ-018 On the edge processing nibble 3 (E+4), SHALL compute overflow = (A[15]==Beff[15]) && (raw[15]!=A[15]) and go to DONE.
REQ-019 At E+4, SHALL load sum with 0x7FFF if overflow and A[15]=0, with 0x8000 if overflow and A[15]=1, and with raw otherwise.
REQ-020 At E+4, SHALL load ovfl, z and n from the saturated value in the same edge as sum.
REQ-021 busy SHALL be 1 exactly in RUN (4 cycles, E+1..E+4 edges inclusive of state); done SHALL be 1 exactly in DONE (the one cycle following edge E+4).
REQ-022 From DONE, SHALL go to RUN if start=1 (back-to-back, as REQ-015) and to IDLE otherwise.
REQ-023 sum, ovfl, z and n SHALL change only at the DONE-entry edge; they SHALL hold their values through IDLE and any subsequent RUN.
REQ-024 The final carry-out of nibble 3 SHALL be discarded; unsigned carry SHALL NOT affect ovfl or saturation.
REQ-025 a, b and sub changing during RUN SHALL NOT affect the result in progress.

Reset
REQ-026 rst_n=0 SHALL asynchronously force state=IDLE, cnt=0, carry=0, partial sum=0, busy=0, done=0, sum=0x0000, ovfl=0, z=0, n=0.
REQ-027 Reset asserted during RUN SHALL abort the operation; no done pulse SHALL follow and the outputs SHALL remain at reset values until a new operation completes.
REQ-028 After rst_n deasserts, the first accepted start SHALL behave per REQ-015.

Verification
REQ-029 SHALL check: a=0x1234, b=0x1111, sub=0, start at edge E -> busy for 4 cycles; done for 1 cycle after E+4; sum=0x2345, ovfl=0, z=0, n=0.
REQ-030 SHALL check: a=0x7FFF, b=0x0001, sub=0 -> sum=0x7FFF, ovfl=1, n=0, z=0; a=0xFFFF, b=0x0001 -> sum=0x0000, ovfl=0, z=1, with carry rippled through all nibbles.
REQ-031 SHALL check: a=0x8000, b=0x0001, sub=1 -> sum=0x8000, ovfl=1, n=1; a=0x0005, b=0x0005, sub=1 -> sum=0x0000, z=1, ovfl=0.
REQ-032 SHALL check: start held high during RUN with different a/b -> ignored and result unchanged; start=1 in the DONE cycle -> new operation begins with busy in the next cycle and done exactly 5 cycles after the previous done.
REQ-033 SHALL check: rst_n pulsed low during the cycle that processes nibble 2 -> all outputs 0 immediately, no done pulse, FSM in IDLE; the next start completes normally.
REQ-034 SHALL check: sum/flags are stable from one done until the next done, including through a full RUN of the next operation.
